// File: rtl/led_sched_pkg.sv
// Shared types for the status LED scheduler.
// Owner encodings, FSM state encoding and small helpers used by the top.
package led_sched_pkg;

   typedef enum logic [1:0] {
      MODE_HB  = 2'b00,
      MODE_ACT = 2'b01,
      MODE_ERR = 2'b10
   } mode_e;

   typedef enum logic [2:0] {
      S_HB      = 3'd0,
      S_ACT_ON  = 3'd1,
      S_ACT_OFF = 3'd2,
      S_ERR_ON  = 3'd3,
      S_ERR_OFF = 3'd4,
      S_ERR_GAP = 3'd5
   } state_e;

   // Owner reported on the mode pin for a given state.
   function automatic logic [1:0] mode_of(input state_e s);
      logic [1:0] m;
      m = MODE_HB;
      unique case (s)
         S_ACT_ON, S_ACT_OFF:           m = MODE_ACT;
         S_ERR_ON, S_ERR_OFF, S_ERR_GAP: m = MODE_ERR;
         default:                       m = MODE_HB;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing a one-clock tick every DIV clocks.
// Ports: clk, reset (async, active-high), tick_o (1 on the wrap cycle).
module led_tick_gen
   import led_sched_pkg::*;
#(
   parameter logic [25:0] DIV = 26'd2500000
) (
   input  logic clk,
   input  logic reset,
   output logic tick_o
);

   localparam int W = $clog2(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 26'd1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/status_led_sched.sv
// Time-shares one status LED between error code, activity flash and heartbeat.
// Ports: clk, reset (async, active-high), err_code[3:0], act_pulse -> led, mode[1:0].
module status_led_sched
   import led_sched_pkg::*;
#(
   parameter logic [25:0] TICK_DIV        = 26'd2500000,
   parameter logic [7:0]  HB_TICKS        = 8'd10,
   parameter logic [7:0]  ACT_TICKS       = 8'd2,
   parameter logic [7:0]  PULSE_ON_TICKS  = 8'd4,
   parameter logic [7:0]  PULSE_OFF_TICKS = 8'd4,
   parameter logic [7:0]  CODE_GAP_TICKS  = 8'd20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] err_code,
   input  logic       act_pulse,
   output logic       led,
   output logic [1:0] mode
);

   logic       tick;
   state_e     state_q;
   logic [7:0] ph_cnt_q;
   logic [7:0] hb_cnt_q;
   logic [3:0] blink_q;
   logic [3:0] code_q;
   logic       hb_led_q;
   logic       act_pend_q;
   logic       led_q;
   logic [1:0] mode_q;

   logic       err_req;
   logic       act_done;
   logic       on_done;
   logic       off_done;
   logic       gap_done;
   logic [3:0] blink_d;

   led_tick_gen #(
      .DIV(TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick_o(tick)
   );

   assign err_req  = (err_code != 4'd0);
   assign act_done = tick && (ph_cnt_q == ACT_TICKS - 8'd1);
   assign on_done  = tick && (ph_cnt_q == PULSE_ON_TICKS - 8'd1);
   assign off_done = tick && (ph_cnt_q == PULSE_OFF_TICKS - 8'd1);
   assign gap_done = tick && (ph_cnt_q == CODE_GAP_TICKS - 8'd1);
   assign blink_d  = blink_q + 4'd1;

   // Heartbeat runs in every state so it stays in phase across preemption.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hb_cnt_q <= 8'd0;
         hb_led_q <= 1'b0;
      end else if (tick) begin
         if (hb_cnt_q == HB_TICKS - 8'd1) begin
            hb_cnt_q <= 8'd0;
            hb_led_q <= ~hb_led_q;
         end else begin
            hb_cnt_q <= hb_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_HB;
         ph_cnt_q   <= 8'd0;
         blink_q    <= 4'd0;
         code_q     <= 4'd0;
         act_pend_q <= 1'b0;
         led_q      <= 1'b0;
         mode_q     <= MODE_HB;
      end else begin
         // Outputs follow the current state one clock later.
         mode_q <= mode_of(state_q);
         unique case (state_q)
            S_HB:               led_q <= hb_led_q;
            S_ACT_ON, S_ERR_ON: led_q <= 1'b1;
            default:            led_q <= 1'b0;
         endcase

         act_pend_q <= act_pend_q | act_pulse;
         if (tick) begin
            ph_cnt_q <= ph_cnt_q + 8'd1;
         end

         unique case (state_q)
            S_HB: begin
               if (err_req) begin
                  state_q  <= S_ERR_ON;
                  code_q   <= err_code;
                  blink_q  <= 4'd0;
                  ph_cnt_q <= 8'd0;
               end else if (act_pend_q && tick) begin
                  // A request arriving on the start cycle re-arms.
                  state_q    <= S_ACT_ON;
                  ph_cnt_q   <= 8'd0;
                  act_pend_q <= act_pulse;
               end
            end
            S_ACT_ON, S_ACT_OFF: begin
               if (err_req) begin
                  state_q    <= S_ERR_ON;
                  code_q     <= err_code;
                  blink_q    <= 4'd0;
                  ph_cnt_q   <= 8'd0;
                  act_pend_q <= 1'b0;
               end else if (act_done) begin
                  state_q  <= (state_q == S_ACT_ON) ? S_ACT_OFF : S_HB;
                  ph_cnt_q <= 8'd0;
               end
            end
            S_ERR_ON: begin
               if (on_done) begin
                  blink_q  <= blink_d;
                  ph_cnt_q <= 8'd0;
                  state_q  <= (blink_d == code_q) ? S_ERR_GAP : S_ERR_OFF;
               end
            end
            S_ERR_OFF: begin
               if (off_done) begin
                  state_q  <= S_ERR_ON;
                  ph_cnt_q <= 8'd0;
               end
            end
            S_ERR_GAP: begin
               if (gap_done) begin
                  ph_cnt_q <= 8'd0;
                  if (err_req) begin
                     state_q <= S_ERR_ON;
                     code_q  <= err_code;
                     blink_q <= 4'd0;
                  end else begin
                     state_q <= S_HB;
                  end
               end
            end
            default: begin
               state_q  <= S_HB;
               ph_cnt_q <= 8'd0;
            end
         endcase
      end
   end

   assign led  = led_q;
   assign mode = mode_q;

endmodule
